if_queue: RTL and testbench

Instruction-fetch front end for the pipelined DLX core. It owns the fetch PC, issues one word-aligned read per cycle to a synchronous instruction memory, and buffers returned instructions with their link value (PC+8) in a DEPTH-entry FIFO. It feeds the decode stage through a valid/ready handshake and accepts branch/jump redirects from downstream, flushing all queued and in-flight fetches.

---
 rtl/if_queue.sv | 135 +++++++++++++
 tb/tb_if_queue.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_queue.sv
// if_queue: DLX instruction-fetch front end.
// Owns the fetch PC and issues one word-aligned read per cycle to a synchronous
// instruction memory. Returned words and their link value (PC+8) are buffered
// in a DEPTH-entry FIFO that feeds decode over a valid/ready handshake.
// Downstream redirects flush all queued and in-flight fetches.
// Optional feature macro: IFQ_BYPASS_EN (present a response arriving at an empty
// queue on the id_* outputs in the response cycle).
`timescale 1ns/1ps

module if_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc_plus_eight,
   input  logic        id_ready
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned OCC_W = CNT_W + 1;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc_plus_eight;
   } ifq_entry_t;

   ifq_entry_t       r_mem [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;
   logic             r_inflight;
   logic [31:0]      r_inflight_pc;
   logic [31:0]      r_pc;

   logic             w_empty;
   logic             w_rsp_live;
   logic             w_bypass;
   logic             w_pop;
   logic             w_fifo_pop;
   logic             w_push;
   logic [OCC_W-1:0] w_occ;
   ifq_entry_t       w_head_entry;
   ifq_entry_t       w_push_entry;
   logic             w_unused_ok;

   // Low address bits of a redirect target are forced to zero, never read.
   assign w_unused_ok = ^redirect_pc[1:0];

   // Queue status and the response that will land this cycle (unless flushed).
   always_comb begin
      w_empty      = (r_count == '0);
      w_rsp_live   = r_inflight && !redirect;
      w_head_entry = r_mem[r_head];
      w_push_entry = '{instr: imem_rdata, pc_plus_eight: r_inflight_pc + 32'd8};
`ifdef IFQ_BYPASS_EN
      w_bypass     = w_empty && w_rsp_live;
`else
      w_bypass     = 1'b0;
`endif
   end

   // Decode-side presentation: FIFO head, or the live response when bypassing.
   always_comb begin
      id_valid         = 1'b0;
      id_instr         = '0;
      id_pc_plus_eight = '0;
      if (!w_empty) begin
         id_valid         = 1'b1;
         id_instr         = w_head_entry.instr;
         id_pc_plus_eight = w_head_entry.pc_plus_eight;
      end else if (w_bypass) begin
         id_valid         = 1'b1;
         id_instr         = w_push_entry.instr;
         id_pc_plus_eight = w_push_entry.pc_plus_eight;
      end
   end

   // Handshake bookkeeping and fetch request; in-flight reads reserve a slot.
   always_comb begin
      w_pop      = id_valid && id_ready;
      w_fifo_pop = !w_empty && id_ready;
      w_push     = w_rsp_live && !(w_bypass && id_ready);
      w_occ      = OCC_W'(r_count) + OCC_W'(r_inflight) - OCC_W'(w_pop);
      imem_req   = !reset && !redirect && (w_occ < OCC_W'(DEPTH));
      imem_addr  = r_pc;
   end

   // Fetch PC, in-flight tracking, pointers and occupancy; redirect flushes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc          <= {RESET_PC[31:2], 2'b00};
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
         r_head        <= '0;
         r_tail        <= '0;
         r_count       <= '0;
      end else if (redirect) begin
         r_pc       <= {redirect_pc[31:2], 2'b00};
         r_inflight <= 1'b0;
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
      end else begin
         r_inflight <= imem_req;
         if (imem_req) begin
            r_pc          <= r_pc + 32'd4;
            r_inflight_pc <= r_pc;
         end
         if (w_push) begin
            r_tail <= r_tail + PTR_W'(1);
         end
         if (w_fifo_pop) begin
            r_head <= r_head + PTR_W'(1);
         end
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_fifo_pop);
      end
   end

   // FIFO storage; contents are don't-care until counted valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_tail] <= w_push_entry;
      end
   end

endmodule

// File: tb/tb_if_queue.sv
// Directed self-checking bench for if_queue (DEPTH=4, RESET_PC=0).
// The memory model returns the request address as the instruction word.
`timescale 1ns/1ps

module tb_if_queue;

`ifdef IFQ_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc_plus_eight;
   logic        id_ready = 1'b0;

   int n_cmp = 0;
   int n_err = 0;
   logic bp = (LAT == 1);

   if_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk              (clk),
      .reset            (reset),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .imem_rdata       (imem_rdata),
      .redirect         (redirect),
      .redirect_pc      (redirect_pc),
      .id_valid         (id_valid),
      .id_instr         (id_instr),
      .id_pc_plus_eight (id_pc_plus_eight),
      .id_ready         (id_ready)
   );

   always #5 clk = ~clk;

   // Synchronous instruction memory: data = address, one cycle later.
   always @(posedge clk) if (imem_req) imem_rdata <= imem_addr;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      redirect = 1'b0;
      id_ready = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; id_ready = 1'b0; redirect = 1'b0;
      tick(); tick(); #1;
      n_cmp++;
      if ({imem_req, imem_addr, id_valid, id_instr, id_pc_plus_eight} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
         n_err++;
         $display("FAIL reset_state: got req=%b addr=%h v=%b i=%h p=%h exp 0,0,0,0,0",
                  imem_req, imem_addr, id_valid, id_instr, id_pc_plus_eight);
      end
      id_ready = 1'b1; #1;
      n_cmp++;
      if (imem_req !== 1'b0) begin
         n_err++;
         $display("FAIL reset_no_req: got req=%b exp 0", imem_req);
      end
   endtask

   task automatic test_stream();
      logic [31:0] ea, ei, ep;
      logic        ev;
      tick(); reset = 1'b0; #1;
      n_cmp++;
      if ({imem_req, imem_addr, id_valid} !== {1'b1, 32'h0, 1'b0}) begin
         n_err++;
         $display("FAIL stream_c0: got req=%b addr=%h v=%b exp 1,00000000,0", imem_req, imem_addr, id_valid);
      end
      for (int c = 1; c <= 8; c++) begin
         tick(); #1;
         ea = 32'(4 * c);
         ev = (c >= LAT);
         ei = ev ? 32'(4 * (c - LAT)) : 32'h0;
         ep = ev ? ei + 32'd8 : 32'h0;
         n_cmp++;
         if ({imem_req, imem_addr, id_valid, id_instr, id_pc_plus_eight} !== {1'b1, ea, ev, ei, ep}) begin
            n_err++;
            $display("FAIL stream_c%0d: got req=%b addr=%h v=%b i=%h p=%h exp 1,%h,%b,%h,%h",
                     c, imem_req, imem_addr, id_valid, id_instr, id_pc_plus_eight, ea, ev, ei, ep);
         end
      end
   endtask

   task automatic test_full();
      int nreq;
      logic [31:0] ea, ei;
      apply_reset();
      tick(); reset = 1'b0; #1;
      nreq = 0;
      if (imem_req) nreq++;
      for (int c = 1; c <= 9; c++) begin
         tick(); #1;
         if (imem_req) nreq++;
      end
      n_cmp++;
      if (nreq !== 4) begin
         n_err++;
         $display("FAIL full_req_count: got %0d exp 4", nreq);
      end
      n_cmp++;
      if ({id_valid, imem_req, id_instr, id_pc_plus_eight} !== {1'b1, 1'b0, 32'h0, 32'h8}) begin
         n_err++;
         $display("FAIL full_hold: got v=%b req=%b i=%h p=%h exp 1,0,0,8", id_valid, imem_req, id_instr, id_pc_plus_eight);
      end
      for (int k = 0; k < 8; k++) begin
         tick(); id_ready = 1'b1; #1;
         ea = 32'(16 + 4 * k);
         ei = 32'(4 * k);
         n_cmp++;
         if ({imem_req, imem_addr, id_valid, id_instr, id_pc_plus_eight} !== {1'b1, ea, 1'b1, ei, ei + 32'd8}) begin
            n_err++;
            $display("FAIL full_drain_%0d: got req=%b addr=%h v=%b i=%h p=%h exp 1,%h,1,%h,%h",
                     k, imem_req, imem_addr, id_valid, id_instr, id_pc_plus_eight, ea, ei, ei + 32'd8);
         end
      end
   endtask

   task automatic test_redirect();
      apply_reset();
      tick(); reset = 1'b0;
      repeat (4) tick();
      redirect = 1'b1; redirect_pc = 32'h0000_0103; #1;
      n_cmp++;
      if ({imem_req, id_valid, id_instr, id_pc_plus_eight} !== {1'b0, 1'b1, 32'h0, 32'h8}) begin
         n_err++;
         $display("FAIL redir_cycle: got req=%b v=%b i=%h p=%h exp 0,1,0,8", imem_req, id_valid, id_instr, id_pc_plus_eight);
      end
      tick(); redirect = 1'b0; #1;
      n_cmp++;
      if ({imem_req, imem_addr, id_valid} !== {1'b1, 32'h0000_0100, 1'b0}) begin
         n_err++;
         $display("FAIL redir_new_pc: got req=%b addr=%h v=%b exp 1,00000100,0", imem_req, imem_addr, id_valid);
      end
      tick(); #1;
      n_cmp++;
      if ({imem_req, imem_addr, id_valid} !== {1'b1, 32'h0000_0104, bp}) begin
         n_err++;
         $display("FAIL redir_next: got req=%b addr=%h v=%b exp 1,00000104,%b", imem_req, imem_addr, id_valid, bp);
      end
      tick(); #1;
      n_cmp++;
      if ({id_valid, id_instr, id_pc_plus_eight} !== {1'b1, 32'h0000_0100, 32'h0000_0108}) begin
         n_err++;
         $display("FAIL redir_head: got v=%b i=%h p=%h exp 1,00000100,00000108", id_valid, id_instr, id_pc_plus_eight);
      end
   endtask

   task automatic test_redirect_pop();
      apply_reset();
      tick(); reset = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0020; #1;
      n_cmp++;
      if (imem_req !== 1'b0) begin
         n_err++;
         $display("FAIL rpop_no_req: got req=%b exp 0", imem_req);
      end
      tick(); redirect = 1'b0; #1;
      n_cmp++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0020}) begin
         n_err++;
         $display("FAIL rpop_first: got req=%b addr=%h exp 1,00000020", imem_req, imem_addr);
      end
      tick(); tick();
      id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0300; #1;
      n_cmp++;
      if ({imem_req, id_valid, id_instr, id_pc_plus_eight} !== {1'b0, 1'b1, 32'h0000_0020, 32'h0000_0028}) begin
         n_err++;
         $display("FAIL rpop_head: got req=%b v=%b i=%h p=%h exp 0,1,00000020,00000028",
                  imem_req, id_valid, id_instr, id_pc_plus_eight);
      end
      tick(); redirect = 1'b0; #1;
      n_cmp++;
      if ({imem_req, imem_addr, id_valid, id_instr} !== {1'b1, 32'h0000_0300, 1'b0, 32'h0}) begin
         n_err++;
         $display("FAIL rpop_flushed: got req=%b addr=%h v=%b i=%h exp 1,00000300,0,0", imem_req, imem_addr, id_valid, id_instr);
      end
      repeat (LAT) tick();
      #1;
      n_cmp++;
      if ({id_valid, id_instr, id_pc_plus_eight} !== {1'b1, 32'h0000_0300, 32'h0000_0308}) begin
         n_err++;
         $display("FAIL rpop_resume: got v=%b i=%h p=%h exp 1,00000300,00000308", id_valid, id_instr, id_pc_plus_eight);
      end
   endtask

   task automatic test_wrap();
      tick(); redirect = 1'b1; redirect_pc = 32'h0000_0500; #1;
      n_cmp++;
      if (imem_req !== 1'b0) begin
         n_err++;
         $display("FAIL wrap_redir1: got req=%b exp 0", imem_req);
      end
      tick(); redirect_pc = 32'hFFFF_FFFF; #1;
      n_cmp++;
      if (imem_req !== 1'b0) begin
         n_err++;
         $display("FAIL wrap_redir2: got req=%b exp 0", imem_req);
      end
      tick(); redirect = 1'b0; #1;
      n_cmp++;
      if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
         n_err++;
         $display("FAIL wrap_last_wins: got req=%b addr=%h exp 1,fffffffc", imem_req, imem_addr);
      end
      tick(); #1;
      n_cmp++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
         n_err++;
         $display("FAIL wrap_addr: got req=%b addr=%h exp 1,00000000", imem_req, imem_addr);
      end
      repeat (LAT - 1) begin
         tick(); #1;
      end
      n_cmp++;
      if ({id_valid, id_instr, id_pc_plus_eight} !== {1'b1, 32'hFFFF_FFFC, 32'h0000_0004}) begin
         n_err++;
         $display("FAIL wrap_link: got v=%b i=%h p=%h exp 1,fffffffc,00000004", id_valid, id_instr, id_pc_plus_eight);
      end
      tick(); #1;
      n_cmp++;
      if ({id_valid, id_instr, id_pc_plus_eight} !== {1'b1, 32'h0, 32'h0000_0008}) begin
         n_err++;
         $display("FAIL wrap_after: got v=%b i=%h p=%h exp 1,00000000,00000008", id_valid, id_instr, id_pc_plus_eight);
      end
   endtask

   task automatic test_async_reset();
      tick(); id_ready = 1'b0;
      repeat (8) tick();
      #1;
      n_cmp++;
      if ({id_valid, imem_req} !== {1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL areset_full: got v=%b req=%b exp 1,0", id_valid, imem_req);
      end
      id_ready = 1'b1; #1;
      n_cmp++;
      if (imem_req !== 1'b1) begin
         n_err++;
         $display("FAIL areset_pop_req: got req=%b exp 1", imem_req);
      end
      #2; reset = 1'b1; #1;
      n_cmp++;
      if ({imem_req, imem_addr, id_valid, id_instr, id_pc_plus_eight} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
         n_err++;
         $display("FAIL areset_drop: got req=%b addr=%h v=%b i=%h p=%h exp 0,0,0,0,0",
                  imem_req, imem_addr, id_valid, id_instr, id_pc_plus_eight);
      end
      tick(); reset = 1'b0; #1;
      n_cmp++;
      if ({imem_req, imem_addr, id_valid} !== {1'b1, 32'h0, 1'b0}) begin
         n_err++;
         $display("FAIL areset_restart: got req=%b addr=%h v=%b exp 1,00000000,0", imem_req, imem_addr, id_valid);
      end
      tick(); #1;
      n_cmp++;
      if ({imem_req, imem_addr, id_valid} !== {1'b1, 32'h4, bp}) begin
         n_err++;
         $display("FAIL areset_next: got req=%b addr=%h v=%b exp 1,00000004,%b", imem_req, imem_addr, id_valid, bp);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_full();
      test_redirect();
      test_redirect_pop();
      test_wrap();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
